// File: rtl/div_signed_sequencer.sv
// rtl/div_signed_sequencer.sv - signed/unsigned front-end sequencer for the restoring divider core
module div_signed_sequencer #(
   parameter int TIMEOUT_CYCLES = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_signed,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_quo,
   output logic [31:0] resp_rem,
   output logic        resp_dbz,
   output logic        resp_err,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   output logic        core_start,
   input  logic [32:0] core_quo,
   input  logic [31:0] core_rem,
   input  logic        core_finish
);

   typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, DONE} seqState;

   localparam logic [6:0] timeoutLast = 7'(TIMEOUT_CYCLES - 1);

   seqState     state, nextState;
   logic [6:0]  waitCnt;
   logic        negQ, negR;
   logic [31:0] magA, magB;
   logic        isDbz, isOvf;
   logic        accept, finishHit, timeoutHit;
   logic        unusedQuoMsb;

   assign unusedQuoMsb = core_quo[32];

   assign magA  = (req_signed && req_a[31]) ? 32'd0 - req_a : req_a;
   assign magB  = (req_signed && req_b[31]) ? 32'd0 - req_b : req_b;
   assign isDbz = (req_b == 32'd0);
   assign isOvf = req_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);

   assign req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState  = state;
      accept     = 1'b0;
      finishHit  = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               nextState = (isDbz || isOvf) ? DONE : LAUNCH;
            end
         end
         LAUNCH: nextState = ARM;
         // A finish still high from the previous operation must drop before WAIT trusts it.
         ARM: begin
            if (waitCnt == timeoutLast) begin
               timeoutHit = 1'b1;
               nextState  = DONE;
            end else if (!core_finish) begin
               nextState = WAIT;
            end
         end
         WAIT: begin
            if (core_finish) begin
               finishHit = 1'b1;
               nextState = DONE;
            end else if (waitCnt == timeoutLast) begin
               timeoutHit = 1'b1;
               nextState  = DONE;
            end
         end
         DONE: if (resp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         negQ       <= 1'b0;
         negR       <= 1'b0;
         waitCnt    <= 7'd0;
         core_a     <= 32'd0;
         core_b     <= 32'd0;
         core_start <= 1'b0;
         resp_valid <= 1'b0;
         resp_quo   <= 32'd0;
         resp_rem   <= 32'd0;
         resp_dbz   <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         core_start <= 1'b0;
         if (accept) begin
            negQ     <= req_signed & (req_a[31] ^ req_b[31]);
            negR     <= req_signed & req_a[31];
            core_a   <= magA;
            core_b   <= magB;
            resp_dbz <= isDbz;
            resp_err <= 1'b0;
            if (isDbz) begin
               resp_quo   <= 32'hFFFF_FFFF;
               resp_rem   <= req_a;
               resp_valid <= 1'b1;
            end else if (isOvf) begin
               resp_quo   <= 32'h8000_0000;
               resp_rem   <= 32'd0;
               resp_valid <= 1'b1;
            end else begin
               core_start <= 1'b1;
            end
         end

         if (state == LAUNCH)                       waitCnt <= 7'd0;
         else if (state == ARM || state == WAIT)    waitCnt <= waitCnt + 7'd1;

         if (finishHit) begin
            resp_quo   <= negQ ? 32'd0 - core_quo[31:0] : core_quo[31:0];
            resp_rem   <= negR ? 32'd0 - core_rem : core_rem;
            resp_valid <= 1'b1;
         end

         if (timeoutHit) begin
            resp_quo   <= 32'd0;
            resp_rem   <= 32'd0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
         end

         if (state == DONE && resp_ready) resp_valid <= 1'b0;
      end
   end

endmodule
